// File: rtl/zap_shift_pipe_pkg.sv
// Shared shifter definitions: op encodings, port widths and the helper that
// spreads barrel levels across pipeline stages.
package zap_shift_pipe_pkg;

    localparam int unsigned AMOUNT_WDT     = 8;
    localparam int unsigned SHIFT_TYPE_WDT = 3;

    typedef enum logic [SHIFT_TYPE_WDT-1:0] {
        SHIFT_LSL = 3'd0,
        SHIFT_LSR = 3'd1,
        SHIFT_ASR = 3'd2,
        SHIFT_ROR = 3'd3,
        SHIFT_RRC = 3'd4
    } shift_op_e;

    // First barrel level owned by a stage; stage k owns [level_lo(k), level_lo(k+1)).
    function automatic int unsigned level_lo(input int unsigned stage,
                                             input int unsigned levels,
                                             input int unsigned stages);
        return (stage * levels) / stages;
    endfunction

endpackage

// File: rtl/zap_shift_pipe_slice.sv
// One pipeline register with a valid bit; loads whenever it is empty or its
// contents are being taken downstream in the same cycle, so bubbles collapse.
module zap_shift_pipe_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_take,
    output logic             o_load,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_load  = !r_valid || i_take;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (o_load) begin
                r_valid <= i_valid;
            end
            if (o_load && i_valid && !i_flush) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/zap_shift_pipe.sv
// Pipelined ARM barrel shifter: every op is decoded up front into a right
// rotate plus a keep-mask and fill bit; rotate levels are spread over STAGES.
module zap_shift_pipe
    import zap_shift_pipe_pkg::*;
#(
    parameter int unsigned DATA_WDT = 32,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned TAG_WDT  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_WDT-1:0]       i_source,
    input  logic [AMOUNT_WDT-1:0]     i_amount,
    input  logic                      i_carry,
    input  logic [SHIFT_TYPE_WDT-1:0] i_shift_type,
    input  logic [TAG_WDT-1:0]        i_tag,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_WDT-1:0]       o_result,
    output logic                      o_carry,
    output logic                      o_zero,
    output logic [TAG_WDT-1:0]        o_tag
);

    localparam int unsigned L         = $clog2(DATA_WDT);
    localparam int unsigned ROT_LSB   = DATA_WDT;
    localparam int unsigned MASK_LSB  = DATA_WDT + L;
    localparam int unsigned FILL_BIT  = 2 * DATA_WDT + L;
    localparam int unsigned CARRY_BIT = FILL_BIT + 1;
    localparam int unsigned TAG_LSB   = FILL_BIT + 2;
    localparam int unsigned IW        = TAG_LSB + TAG_WDT;
    localparam int unsigned FW        = DATA_WDT + 2 + TAG_WDT;
    localparam logic [8:0]  W9        = 9'(DATA_WDT);

    logic [DATA_WDT-1:0] w_ones;
    logic [8:0]          w_n;
    logic [L-1:0]        w_nlo;
    logic [L-1:0]        w_neg;
    logic [L-1:0]        w_nm1;
    logic                w_in_range;

    logic [L-1:0]        w_dec_rot;
    logic [DATA_WDT-1:0] w_dec_mask;
    logic                w_dec_fill;
    logic                w_dec_carry;

    logic [IW-1:0]       w_stage_in [STAGES];
    logic [STAGES-1:0]   w_valid;
    logic [STAGES-1:0]   w_load;

    assign w_ones     = '1;
    assign w_n        = {1'b0, i_amount};
    assign w_nlo      = i_amount[L-1:0];
    assign w_neg      = '0 - w_nlo;
    assign w_nm1      = w_nlo - {{(L-1){1'b0}}, 1'b1};
    assign w_in_range = (i_amount != '0) && (w_n < W9);

    always_comb begin
        w_dec_rot   = '0;
        w_dec_mask  = w_ones;
        w_dec_fill  = 1'b0;
        w_dec_carry = i_carry;
        case (i_shift_type)
            SHIFT_LSL: begin
                if (w_n == W9) begin
                    w_dec_mask  = '0;
                    w_dec_carry = i_source[0];
                end else if (w_n > W9) begin
                    w_dec_mask  = '0;
                    w_dec_carry = 1'b0;
                end else if (w_in_range) begin
                    w_dec_rot   = w_neg;
                    w_dec_mask  = w_ones << i_amount;
                    w_dec_carry = i_source[w_neg];
                end
            end
            SHIFT_LSR: begin
                if (w_n == W9) begin
                    w_dec_mask  = '0;
                    w_dec_carry = i_source[DATA_WDT-1];
                end else if (w_n > W9) begin
                    w_dec_mask  = '0;
                    w_dec_carry = 1'b0;
                end else if (w_in_range) begin
                    w_dec_rot   = w_nlo;
                    w_dec_mask  = w_ones >> i_amount;
                    w_dec_carry = i_source[w_nm1];
                end
            end
            SHIFT_ASR: begin
                if (w_n >= W9) begin
                    w_dec_mask  = '0;
                    w_dec_fill  = i_source[DATA_WDT-1];
                    w_dec_carry = i_source[DATA_WDT-1];
                end else if (w_in_range) begin
                    w_dec_rot   = w_nlo;
                    w_dec_mask  = w_ones >> i_amount;
                    w_dec_fill  = i_source[DATA_WDT-1];
                    w_dec_carry = i_source[w_nm1];
                end
            end
            SHIFT_ROR: begin
                // A multiple of W rotates by zero and w_nm1 wraps to W-1, giving src[W-1].
                if (i_amount != '0) begin
                    w_dec_rot   = w_nlo;
                    w_dec_carry = i_source[w_nm1];
                end
            end
            SHIFT_RRC: begin
                w_dec_rot   = {{(L-1){1'b0}}, 1'b1};
                w_dec_mask  = w_ones >> 1;
                w_dec_fill  = i_carry;
                w_dec_carry = i_source[0];
            end
            default: ;
        endcase
    end

    assign w_stage_in[0] = {i_tag, w_dec_carry, w_dec_fill, w_dec_mask, w_dec_rot, i_source};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = level_lo(k, L, STAGES);
        localparam int unsigned HI = level_lo(k + 1, L, STAGES);

        logic [DATA_WDT-1:0] w_rot;
        logic                w_up_valid;

        always_comb begin
            w_rot = w_stage_in[k][DATA_WDT-1:0];
            for (int unsigned j = 0; j < L; j++) begin
                if (((j - LO) < (HI - LO)) && w_stage_in[k][ROT_LSB + j]) begin
                    w_rot = (w_rot >> (1 << j)) | (w_rot << (DATA_WDT - (1 << j)));
                end
            end
        end

        if (k == 0) begin : g_first
            assign w_up_valid = i_valid;
        end else begin : g_later
            assign w_up_valid = w_valid[k-1];
        end

        if (k == STAGES - 1) begin : g_last
            logic [DATA_WDT-1:0] w_mask;
            logic [DATA_WDT-1:0] w_result;
            logic                w_zero;
            logic [FW-1:0]       w_out;

            assign w_mask   = w_stage_in[k][MASK_LSB +: DATA_WDT];
            assign w_result = (w_rot & w_mask) |
                              ({DATA_WDT{w_stage_in[k][FILL_BIT]}} & ~w_mask);
            assign w_zero   = (w_result == '0);

            zap_shift_pipe_slice #(.WIDTH(FW)) u_slice (
                .i_clk    (i_clk),
                .i_reset_n(i_reset_n),
                .i_flush  (i_flush),
                .i_valid  (w_up_valid),
                .i_data   ({w_stage_in[k][TAG_LSB +: TAG_WDT], w_zero,
                            w_stage_in[k][CARRY_BIT], w_result}),
                .i_take   (i_ready),
                .o_load   (w_load[k]),
                .o_valid  (w_valid[k]),
                .o_data   (w_out)
            );

            assign o_result = w_out[DATA_WDT-1:0];
            assign o_carry  = w_out[DATA_WDT];
            assign o_zero   = w_out[DATA_WDT+1];
            assign o_tag    = w_out[DATA_WDT+2 +: TAG_WDT];
        end else begin : g_inner
            zap_shift_pipe_slice #(.WIDTH(IW)) u_slice (
                .i_clk    (i_clk),
                .i_reset_n(i_reset_n),
                .i_flush  (i_flush),
                .i_valid  (w_up_valid),
                .i_data   ({w_stage_in[k][IW-1:DATA_WDT], w_rot}),
                .i_take   (w_load[k+1]),
                .o_load   (w_load[k]),
                .o_valid  (w_valid[k]),
                .o_data   (w_stage_in[k+1])
            );
        end
    end

    assign o_ready = w_load[0];
    assign o_valid = w_valid[STAGES-1];

endmodule
